// File: rtl/glonass_prn_gen_if.sv
// Control and observation bundle for the GLONASS-style PRN generator.
// Widths follow the generator's stage count and chip-index width.
interface glonass_prn_gen_if #(
   parameter int N  = 9,
   parameter int CW = 9
);
   logic          chip_en;
   logic          load;
   logic          slew_valid;
   logic [CW-1:0] slew_chips;
   logic          slew_ready;
   logic          chip;
   logic [CW-1:0] chip_idx;
   logic          epoch;
   logic [N-1:0]  code_state;

   modport master (
      output chip_en, load, slew_valid, slew_chips,
      input  slew_ready, chip, chip_idx, epoch, code_state
   );

   modport slave (
      input  chip_en, load, slew_valid, slew_chips,
      output slew_ready, chip, chip_idx, epoch, code_state
   );
endinterface

// File: rtl/glonass_prn_gen.sv
// Parametrised Fibonacci LFSR ranging-code generator with truncated-code
// wrap, epoch strobe, synchronous reload and handshaked code-phase slew.
//
// state | meaning
// IDLE  | advance on chip_en only; slew requests accepted
// SLEW  | advance every cycle until the requested extra chips are consumed
module glonass_prn_gen #(
   parameter int           N        = 9,
   parameter logic [N-1:0] TAP_MASK = 9'h110,
   parameter logic [N-1:0] SEED     = 9'h1FF,
   parameter int           OUT_TAP  = 7,
   parameter int           CODE_LEN = 511,
   parameter int           CW       = $clog2(CODE_LEN)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   glonass_prn_gen_if.slave      bus
);

   localparam logic [CW-1:0] LAST_IDX = CW'(CODE_LEN - 1);

   typedef enum logic {IDLE, SLEW} fsm_t;

   fsm_t          fsm_q, fsm_d;
   logic [CW-1:0] rem_q, rem_d;
   logic [N-1:0]  lfsr_q;
   logic [CW-1:0] idx_q;
   logic          epoch_q;
   logic          adv;
   logic          fb;

   assign fb = ^(lfsr_q & TAP_MASK);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fsm_q <= IDLE;
         rem_q <= '0;
      end else begin
         fsm_q <= fsm_d;
         rem_q <= rem_d;
      end
   end

   // A chip_en during SLEW supplies that cycle's advance, so rem holds.
   always_comb begin
      fsm_d = fsm_q;
      rem_d = rem_q;
      adv   = 1'b0;
      case (fsm_q)
         IDLE: begin
            adv = bus.chip_en;
            if (bus.slew_valid && (bus.slew_chips != '0)) begin
               fsm_d = SLEW;
               rem_d = bus.slew_chips;
            end
         end
         SLEW: begin
            adv = 1'b1;
            if (!bus.chip_en) begin
               rem_d = rem_q - 1'b1;
               if (rem_q == CW'(1)) fsm_d = IDLE;
            end
         end
         default: fsm_d = IDLE;
      endcase
      if (bus.load) begin
         fsm_d = IDLE;
         rem_d = '0;
         adv   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_q  <= SEED;
         idx_q   <= '0;
         epoch_q <= 1'b0;
      end else if (bus.load) begin
         lfsr_q  <= SEED;
         idx_q   <= '0;
         epoch_q <= 1'b0;
      end else if (adv) begin
         if (idx_q == LAST_IDX) begin
            lfsr_q  <= SEED;
            idx_q   <= '0;
            epoch_q <= 1'b1;
         end else begin
            lfsr_q  <= {lfsr_q[N-2:0], fb};
            idx_q   <= idx_q + 1'b1;
            epoch_q <= 1'b0;
         end
      end else begin
         epoch_q <= 1'b0;
      end
   end

   assign bus.slew_ready = (fsm_q == IDLE);
   assign bus.chip       = lfsr_q[OUT_TAP-1];
   assign bus.chip_idx   = idx_q;
   assign bus.epoch      = epoch_q;
   assign bus.code_state = lfsr_q;

endmodule

// File: tb/tb_glonass_prn_gen.sv
// Directed bench for glonass_prn_gen: default 511-chip build plus a
// 7-chip truncated build sharing clock and reset.
module tb_glonass_prn_gen;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   int   ep_cnt = 0;

   always #5 clk = ~clk;

   glonass_prn_gen_if #(.N(9), .CW(9)) bus ();
   glonass_prn_gen_if #(.N(9), .CW(3)) bus7 ();

   glonass_prn_gen u_dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
   glonass_prn_gen #(.CODE_LEN(7)) u_dut7 (.clk(clk), .reset_n(reset_n), .bus(bus7.slave));

   always @(negedge clk) if (bus.epoch) ep_cnt <= ep_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference x^9+x^5+1 step: stage1 <= s9 ^ s5, stage k+1 <= stage k.
   function automatic logic [8:0] ref_next(input logic [8:0] s);
      return {s[7:0], s[8] ^ s[4]};
   endfunction

   function automatic logic [8:0] ref_state(input int n);
      logic [8:0] s = 9'h1FF;
      for (int i = 0; i < (n % 511); i++) s = ref_next(s);
      return s;
   endfunction

   task automatic do_load();
      bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       exp_chip [8];
      logic [8:0] ms;
      logic       c7 [7];
      int         bad;
      int         ones;

      exp_chip = '{1, 1, 1, 1, 1, 1, 1, 0};
      bus.chip_en = 0; bus.load = 0; bus.slew_valid = 0; bus.slew_chips = '0;
      bus7.chip_en = 0; bus7.load = 0; bus7.slew_valid = 0; bus7.slew_chips = '0;

      #12;
      chk("rst_state", bus.code_state, 9'h1FF);
      chk("rst_idx", bus.chip_idx, 0);
      chk("rst_epoch", bus.epoch, 0);
      chk("rst_ready", bus.slew_ready, 1);
      chk("rst_chip", bus.chip, 1);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Eight spaced strobes; chip observed before each advance.
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.chip !== exp_chip[i]) bad++;
         bus.chip_en = 1'b1;
         tick();
         bus.chip_en = 1'b0;
         if (i == 6) chk("state_after7", bus.code_state, 9'h183);
         tick();
         tick();
      end
      chk("chip_seq8", bad, 0);
      chk("idx_after8", bus.chip_idx, 8);

      // Full-length sequence against the reference model.
      do_load();
      bad = 0;
      ones = 0;
      ms = 9'h1FF;
      bus.chip_en = 1'b1;
      for (int i = 0; i < 510; i++) begin
         if (bus.code_state !== ms || bus.chip !== ms[6]) bad++;
         ones += int'(bus.chip);
         ms = ref_next(ms);
         tick();
      end
      bus.chip_en = 1'b0;
      if (bus.code_state !== ms || bus.chip !== ms[6]) bad++;
      ones += int'(bus.chip);
      chk("seq511_model", bad, 0);
      chk("seq511_ones", ones, 256);
      chk("idx_510", bus.chip_idx, 510);
      chk("epoch_pre_wrap", bus.epoch, 0);
      bus.chip_en = 1'b1;
      tick();
      bus.chip_en = 1'b0;
      chk("wrap_idx", bus.chip_idx, 0);
      chk("wrap_state", bus.code_state, 9'h1FF);
      chk("wrap_epoch", bus.epoch, 1);
      tick();
      chk("wrap_epoch_clr", bus.epoch, 0);

      // Truncated 7-chip code.
      bad = 0;
      bus7.chip_en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         c7[i] = bus7.chip;
         tick();
      end
      bus7.chip_en = 1'b0;
      chk("c7_state", bus7.code_state, 9'h1FF);
      chk("c7_idx", bus7.chip_idx, 0);
      chk("c7_epoch", bus7.epoch, 1);
      bus7.chip_en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         if (bus7.chip !== c7[i]) bad++;
         tick();
      end
      bus7.chip_en = 1'b0;
      chk("c7_repeat", bad, 0);
      tick();
      chk("c7_epoch_clr", bus7.epoch, 0);

      // Slew of 5 with chip_en idle.
      do_load();
      bus.slew_valid = 1'b1;
      bus.slew_chips = 9'd5;
      tick();
      bus.slew_valid = 1'b0;
      bad = 0;
      for (int k = 1; k <= 5; k++) begin
         if (bus.slew_ready !== 1'b0 || bus.chip_idx !== 9'(k - 1)) bad++;
         tick();
      end
      chk("slew5_window", bad, 0);
      chk("slew5_ready", bus.slew_ready, 1);
      chk("slew5_idx", bus.chip_idx, 5);
      chk("slew5_state", bus.code_state, 9'h1E0);

      // Zero-chip slew: no handshake effect, no advance.
      bus.slew_valid = 1'b1;
      bus.slew_chips = 9'd0;
      tick();
      bus.slew_valid = 1'b0;
      chk("slew0_ready", bus.slew_ready, 1);
      tick();
      chk("slew0_idx", bus.chip_idx, 5);

      // Slew across the wrap with two chip_en pulses absorbed.
      do_load();
      bus.chip_en = 1'b1;
      repeat (508) tick();
      bus.chip_en = 1'b0;
      chk("pre_slew_idx", bus.chip_idx, 508);
      ep_cnt = 0;
      bus.slew_valid = 1'b1;
      bus.slew_chips = 9'd5;
      tick();                                   // T+1
      bus.slew_valid = 1'b0;
      tick();                                   // T+2
      bus.chip_en = 1'b1;
      tick();                                   // T+3
      bus.chip_en = 1'b0;
      tick();                                   // T+4
      bus.chip_en = 1'b1;
      tick();                                   // T+5
      bus.chip_en = 1'b0;
      tick();                                   // T+6
      tick();                                   // T+7
      chk("wslew_busy_t7", bus.slew_ready, 0);
      chk("wslew_idx_t7", bus.chip_idx, 3);
      tick();                                   // T+8
      chk("wslew_ready_t8", bus.slew_ready, 1);
      chk("wslew_idx", bus.chip_idx, 4);
      chk("wslew_state", bus.code_state, ref_state(4));
      tick();
      chk("wslew_epochs", ep_cnt, 1);
      chk("wslew_hold", bus.chip_idx, 4);

      // load at T+3 of a 5-chip slew, slew_valid coincident with load.
      do_load();
      bus.slew_valid = 1'b1;
      bus.slew_chips = 9'd5;
      tick();                                   // T+1
      bus.slew_valid = 1'b0;
      tick();                                   // T+2
      tick();                                   // T+3
      bus.load = 1'b1;
      bus.slew_valid = 1'b1;
      tick();                                   // T+4
      bus.load = 1'b0;
      bus.slew_valid = 1'b0;
      chk("ld_idx", bus.chip_idx, 0);
      chk("ld_state", bus.code_state, 9'h1FF);
      chk("ld_ready", bus.slew_ready, 1);
      repeat (4) tick();
      chk("ld_no_adv", bus.chip_idx, 0);

      // slew_valid with load while idle is not accepted.
      bus.load = 1'b1;
      bus.slew_valid = 1'b1;
      bus.slew_chips = 9'd3;
      tick();
      bus.load = 1'b0;
      bus.slew_valid = 1'b0;
      chk("ldv_ready", bus.slew_ready, 1);
      repeat (3) tick();
      chk("ldv_idx", bus.chip_idx, 0);

      // Asynchronous reset mid-slew.
      bus.slew_valid = 1'b1;
      bus.slew_chips = 9'd5;
      tick();
      bus.slew_valid = 1'b0;
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_idx", bus.chip_idx, 0);
      chk("arst_state", bus.code_state, 9'h1FF);
      chk("arst_ready", bus.slew_ready, 1);
      chk("arst_epoch", bus.epoch, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) tick();
      chk("arst_no_adv", bus.chip_idx, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/glonass_prn_gen.md
Name: glonass_prn_gen

Overview:
- Parametrised Fibonacci LFSR ranging-code generator, the successor of the fixed 9-stage GLONASS generator (x^9 + x^5 + 1, length 511, all-ones seed, output from stage 7).
- Adds:
  - configurable polynomial, seed, output tap and code length (truncated codes);
  - a chip-rate enable;
  - a code-phase index and an epoch strobe;
  - synchronous reload;
  - a handshaked code-phase slew used by the acquisition/tracking loop.

Parameters:
- N, 9, LFSR stage count (stages numbered 1..N).
- TAP_MASK, 9'h110, feedback stages; bit k-1 = stage k (default: stages 9 and 5).
- SEED, 9'h1FF, reset/reload state; bit k-1 = stage k.
- OUT_TAP, 7, stage driven onto chip (1..N).
- CODE_LEN, 511, chips per code epoch (2..2^N-1).
- CW, $clog2(CODE_LEN), width of chip_idx and slew_chips.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- chip_en  in  1  one-cycle strobe; advance code by one chip.
- load  in  1  synchronous reload to SEED / index 0.
- slew_valid  in  1  slew request.
- slew_chips  in  CW  extra chips to advance.
- slew_ready  out  1  high when a slew can be accepted.
- chip  out  1  current code chip = state stage OUT_TAP.
- chip_idx  out  CW  current chip number, 0..CODE_LEN-1.
- epoch  out  1  one-cycle pulse on wrap to chip 0.
- code_state  out  N  full LFSR state; bit k-1 = stage k.

Behaviour:
- Clock and reset: clk; reset_n asynchronous, active-low.
- Reset values:
  - state = SEED, chip_idx = 0, epoch = 0, FSM = IDLE, slew_ready = 1;
  - chip = SEED[OUT_TAP-1] (1 for defaults).
- "Advance" (one chip):
  - If chip_idx == CODE_LEN-1: chip_idx <= 0, state <= SEED, epoch <= 1 next cycle.
  - Otherwise: chip_idx <= chip_idx+1; stage1 <= XOR of stages selected by TAP_MASK; stage k+1 <= stage k.
  - For maximal-length CODE_LEN the seed reload equals the natural successor.
- All outputs are registered or derived directly from registers; the first advance is visible the cycle after the strobe.
- epoch is high for exactly one cycle per wrap, otherwise 0.
- FSM IDLE:
  - slew_ready = 1.
  - chip_en = 1 → one advance.
  - slew_valid & slew_ready → rem <= slew_chips; go to SLEW, or stay IDLE if slew_chips == 0.
  - A chip_en in the acceptance cycle is still honoured.
- FSM SLEW:
  - slew_ready = 0.
  - Exactly one advance every cycle.
  - rem decrements only on cycles where chip_en = 0; a chip_en during SLEW absorbs that cycle's advance, so no chip is lost or doubled.
  - Return to IDLE in the cycle after the advance that leaves rem == 0.
  - slew_valid is ignored in SLEW.
  - chip_en held high continuously stalls completion; the system guarantees chip_en duty < 1.
- Slew crossing a wrap: each wrap produces its own epoch pulse; chip_idx wraps modulo CODE_LEN.
- load:
  - Overrides chip_en and slew in the same cycle: state <= SEED, chip_idx <= 0, FSM <= IDLE, epoch <= 0.
  - An in-progress slew is discarded.
  - A slew_valid coincident with load is not accepted (slew_ready is still the registered value, but the handshake is ignored).
- Reset asserted mid-slew: immediate return to reset values.

Test Plan:
- Reset, then 8 single-cycle chip_en strobes spaced 3 cycles apart → chip sequence (before each advance) 1,1,1,1,1,1,1,0; code_state after the 7th advance = stages 1..9 = 110000011 (code_state = 9'h183).
- 510 advances → chip_idx = 510, epoch = 0. Next advance → chip_idx = 0, code_state = 9'h1FF, epoch high exactly 1 cycle. The full 511-chip sequence matches a reference LFSR model and contains 256 ones.
- Build with CODE_LEN = 7, 7 advances → state reloads 9'h1FF, chip_idx = 0, epoch pulse; next 7 chips repeat the first 7.
- Slew handshake, chip_en idle:
  - slew_chips = 5 accepted at cycle T → slew_ready = 0 for T+1..T+5, advances on T+1..T+5, slew_ready = 1 at T+6;
  - chip_idx = 5, state equals 5 normal advances.
  - slew_chips = 0 → slew_ready never drops, no advance.
- Slew of 5 from chip_idx 508, with chip_en pulses at T+2 and T+4 → 7 advances total, completion at T+8, chip_idx = 4, exactly one epoch pulse.
- load at T+3 of a 5-chip slew → chip_idx = 0, code_state = 9'h1FF at T+4, slew_ready = 1 at T+4, no further advances. reset_n pulse mid-slew → same values asynchronously.
